// File: rtl/wash_bay_arbiter.sv
// wash_bay_arbiter
//   Shares one washing machine between N_STATIONS coin stations. Pending
//   stations are served round-robin. For each winner the arbiter pulses the
//   machine's coin input, holds the double-wash select, relays the winner's
//   pause request, and waits for a fresh rising edge on wash_done. Completion
//   is acknowledged to the winner. A watchdog aborts a run that never
//   completes and reports the aborted station.
//
// Ports
//   clk             in   1   system clock, rising edge
//   rst             in   1   asynchronous active-high reset
//   req             in   N   level request per station
//   dbl_req         in   N   double-wash select, sampled at grant
//   pause_req       in   N   pause request; only the owner's bit is used
//   grant           out  N   one-hot current owner, 0 when idle
//   busy            out  1   machine owned
//   wm_coin_in      out  1   coin pulse to the machine (START only)
//   wm_double_wash  out  1   double-wash select to the machine
//   wm_timer_pause  out  1   pause relay to the machine (RUN only)
//   wm_wash_done    in   1   wash finished indication from the machine
//   done_ack        out  N   one-cycle completion pulse to the owner
//   fault           out  1   one-cycle pulse on watchdog abort
//   fault_id        out  3   index of the last aborted station
module wash_bay_arbiter #(
  parameter int N_STATIONS  = 4,
  parameter int TIMEOUT_W   = 16,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_STATIONS-1:0] req,
  input  logic [N_STATIONS-1:0] dbl_req,
  input  logic [N_STATIONS-1:0] pause_req,
  output logic [N_STATIONS-1:0] grant,
  output logic                  busy,
  output logic                  wm_coin_in,
  output logic                  wm_double_wash,
  output logic                  wm_timer_pause,
  input  logic                  wm_wash_done,
  output logic [N_STATIONS-1:0] done_ack,
  output logic                  fault,
  output logic [2:0]            fault_id
);

  localparam int IDX_W = $clog2(N_STATIONS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_DONE,
    S_ABORT
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  // The round-robin pointer doubles as the owner index once a grant is made.
  logic [IDX_W-1:0]       r_rr_ptr;
  logic [TIMEOUT_W-1:0]   r_wd;
  logic                   r_done_prev;
  logic [2:0]             r_fault_id;
  logic                   r_dbl;

  logic                   w_found;
  logic [IDX_W-1:0]       w_win;
  int                     w_idx;
  logic                   w_pause;
  logic                   w_done_edge;
  logic                   w_wd_hit;
  logic [N_STATIONS-1:0]  w_onehot;

  // Round-robin search: first requester strictly after the pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_rr_ptr;
    w_idx   = 0;
    for (int i = 1; i <= N_STATIONS; i++) begin
      w_idx = (int'(r_rr_ptr) + i) % N_STATIONS;
      if (!w_found && req[IDX_W'(w_idx)]) begin
        w_found = 1'b1;
        w_win   = IDX_W'(w_idx);
      end
    end
  end

  assign w_pause     = (r_state == S_RUN) && pause_req[r_rr_ptr];
  // Only a fresh 0->1 transition counts; a level already high is ignored.
  assign w_done_edge = wm_wash_done && !r_done_prev;
  assign w_wd_hit    = !w_pause && (r_wd == TIMEOUT_W'(TIMEOUT_CYC - 1));

  // ---- state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---- next state and outputs ----
  always_comb begin
    w_state_nxt    = r_state;
    w_onehot       = '0;
    w_onehot[r_rr_ptr] = 1'b1;
    grant          = '0;
    busy           = 1'b0;
    wm_coin_in     = 1'b0;
    wm_double_wash = 1'b0;
    wm_timer_pause = 1'b0;
    done_ack       = '0;
    fault          = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) w_state_nxt = S_START;
      end
      S_START: begin
        grant          = w_onehot;
        busy           = 1'b1;
        wm_coin_in     = 1'b1;
        wm_double_wash = r_dbl;
        w_state_nxt    = S_RUN;
      end
      S_RUN: begin
        grant          = w_onehot;
        busy           = 1'b1;
        wm_double_wash = r_dbl;
        wm_timer_pause = w_pause;
        // Completion wins over a timeout landing in the same cycle.
        if (w_done_edge)   w_state_nxt = S_DONE;
        else if (w_wd_hit) w_state_nxt = S_ABORT;
      end
      S_DONE: begin
        grant       = w_onehot;
        busy        = 1'b1;
        done_ack    = w_onehot;
        w_state_nxt = S_IDLE;
      end
      S_ABORT: begin
        grant       = w_onehot;
        busy        = 1'b1;
        fault       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---- control registers: pointer, watchdog, done history, fault id ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr    <= IDX_W'(N_STATIONS - 1);
      r_wd        <= '0;
      r_done_prev <= 1'b0;
      r_fault_id  <= '0;
    end else begin
      r_done_prev <= wm_wash_done;
      if (r_state == S_IDLE && w_found) r_rr_ptr <= w_win;
      if (r_state == S_START) begin
        r_wd <= '0;
      end else if (r_state == S_RUN && !w_pause) begin
        r_wd <= r_wd + 1'b1;
      end
      if (r_state == S_RUN && w_state_nxt == S_ABORT) r_fault_id <= 3'(r_rr_ptr);
    end
  end

  // ---- grant-time data latch ----
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && w_found) r_dbl <= dbl_req[w_win];
  end

  assign fault_id = r_fault_id;

endmodule

// File: tb/tb_wash_bay_arbiter.sv
// Directed bench for wash_bay_arbiter with N_STATIONS=4, TIMEOUT_CYC=40.
module tb_wash_bay_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] dbl_req;
  logic [3:0] pause_req;
  logic [3:0] grant;
  logic       busy;
  logic       wm_coin_in;
  logic       wm_double_wash;
  logic       wm_timer_pause;
  logic       wm_wash_done;
  logic [3:0] done_ack;
  logic       fault;
  logic [2:0] fault_id;

  int errors = 0;
  int checks = 0;

  wash_bay_arbiter #(
    .N_STATIONS (4),
    .TIMEOUT_W  (16),
    .TIMEOUT_CYC(40)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .dbl_req       (dbl_req),
    .pause_req     (pause_req),
    .grant         (grant),
    .busy          (busy),
    .wm_coin_in    (wm_coin_in),
    .wm_double_wash(wm_double_wash),
    .wm_timer_pause(wm_timer_pause),
    .wm_wash_done  (wm_wash_done),
    .done_ack      (done_ack),
    .fault         (fault),
    .fault_id      (fault_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] dbl;
    logic [3:0] g;
    logic       d;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One full transaction from IDLE: grant, coin, run, done edge, ack, release.
  task automatic run_txn(input vec_t v);
    req = v.req;
    dbl_req = v.dbl;
    cyc();
    check("start_grant", 32'(grant), 32'(v.g));
    check("start_coin", 32'(wm_coin_in), 32'd1);
    check("start_dbl", 32'(wm_double_wash), 32'(v.d));
    check("start_busy", 32'(busy), 32'd1);
    dbl_req = 4'b0000;
    cyc();
    check("run_coin", 32'(wm_coin_in), 32'd0);
    check("run_dbl", 32'(wm_double_wash), 32'(v.d));
    check("run_grant", 32'(grant), 32'(v.g));
    wm_wash_done = 1'b1;
    cyc();
    check("done_ack", 32'(done_ack), 32'(v.g));
    check("done_grant", 32'(grant), 32'(v.g));
    check("done_dbl", 32'(wm_double_wash), 32'd0);
    check("done_coin", 32'(wm_coin_in), 32'd0);
    wm_wash_done = 1'b0;
    req = 4'b0000;
    cyc();
    check("idle_grant", 32'(grant), 32'd0);
    check("idle_ack", 32'(done_ack), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL sim_time_limit: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req = '0;
    dbl_req = '0;
    pause_req = '0;
    wm_wash_done = 1'b0;

    // Round-robin pointer resets to 3, so searching starts at station 0.
    vecs[0] = '{req: 4'b0001, dbl: 4'b0000, g: 4'b0001, d: 1'b0};
    vecs[1] = '{req: 4'b1111, dbl: 4'b0000, g: 4'b0010, d: 1'b0};
    vecs[2] = '{req: 4'b1111, dbl: 4'b0000, g: 4'b0100, d: 1'b0};
    vecs[3] = '{req: 4'b1111, dbl: 4'b0000, g: 4'b1000, d: 1'b0};
    vecs[4] = '{req: 4'b1111, dbl: 4'b0000, g: 4'b0001, d: 1'b0};
    vecs[5] = '{req: 4'b0100, dbl: 4'b0100, g: 4'b0100, d: 1'b1};
    vecs[6] = '{req: 4'b1011, dbl: 4'b1000, g: 4'b1000, d: 1'b1};
    vecs[7] = '{req: 4'b0110, dbl: 4'b0010, g: 4'b0010, d: 1'b1};
    vecs[8] = '{req: 4'b0001, dbl: 4'b1110, g: 4'b0001, d: 1'b0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_coin", 32'(wm_coin_in), 32'd0);
    check("rst_dbl", 32'(wm_double_wash), 32'd0);
    check("rst_pause", 32'(wm_timer_pause), 32'd0);
    check("rst_ack", 32'(done_ack), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_fault_id", 32'(fault_id), 32'd0);

    repeat (3) cyc();
    check("no_req_idle", 32'(busy), 32'd0);

    for (int i = 0; i < 9; i++) run_txn(vecs[i]);

    // Held requests: ack at d+1, grant low at d+2, next grant at d+3.
    req = 4'b1111;
    cyc();
    check("held_grant1", 32'(grant), 32'b0010);
    cyc();
    for (int k = 1; k < 20; k++) begin
      check("held_no_ack", 32'(done_ack), 32'd0);
      cyc();
    end
    wm_wash_done = 1'b1;
    cyc();
    check("held_ack", 32'(done_ack), 32'b0010);
    wm_wash_done = 1'b0;
    cyc();
    check("held_gap", 32'(grant), 32'd0);
    cyc();
    check("held_grant2", 32'(grant), 32'b0100);
    check("held_coin2", 32'(wm_coin_in), 32'd1);
    cyc();
    wm_wash_done = 1'b1;
    cyc();
    check("held_ack2", 32'(done_ack), 32'b0100);
    wm_wash_done = 1'b0;
    req = 4'b0000;
    cyc();

    // wash_done already high when RUN starts is not an edge.
    wm_wash_done = 1'b1;
    req = 4'b0001;
    cyc();
    check("lvl_grant", 32'(grant), 32'b0001);
    cyc();
    check("lvl_no_ack1", 32'(done_ack), 32'd0);
    cyc();
    check("lvl_no_ack2", 32'(done_ack), 32'd0);
    check("lvl_still_busy", 32'(grant), 32'b0001);
    wm_wash_done = 1'b0;
    cyc();
    wm_wash_done = 1'b1;
    cyc();
    check("lvl_ack", 32'(done_ack), 32'b0001);
    wm_wash_done = 1'b0;
    req = 4'b0000;
    cyc();

    // Owner pause stretches the watchdog; non-owner pause is ignored; req dropped mid-run.
    req = 4'b0010;
    cyc();
    check("pz_grant", 32'(grant), 32'b0010);
    pause_req = 4'b1010;
    #1;
    check("pz_start_forced0", 32'(wm_timer_pause), 32'd0);
    cyc();
    for (int k = 1; k <= 60; k++) begin
      pause_req = (k <= 30) ? 4'b1010 : 4'b1000;
      if (k == 1) req = 4'b0000;
      wm_wash_done = (k == 60);
      #1;
      check("pz_relay", 32'(wm_timer_pause), (k <= 30) ? 32'd1 : 32'd0);
      check("pz_no_fault", 32'(fault), 32'd0);
      cyc();
    end
    check("pz_ack", 32'(done_ack), 32'b0010);
    check("pz_fault", 32'(fault), 32'd0);
    check("pz_done_pause", 32'(wm_timer_pause), 32'd0);
    wm_wash_done = 1'b0;
    pause_req = 4'b0000;
    cyc();
    check("pz_idle", 32'(grant), 32'd0);

    // Watchdog abort: 40 unpaused RUN cycles, then ABORT.
    req = 4'b0100;
    cyc();
    check("wd_grant", 32'(grant), 32'b0100);
    cyc();
    for (int k = 1; k <= 40; k++) begin
      check("wd_early", 32'(fault), 32'd0);
      cyc();
    end
    check("wd_fault", 32'(fault), 32'd1);
    check("wd_fault_id", 32'(fault_id), 32'd2);
    check("wd_grant_held", 32'(grant), 32'b0100);
    check("wd_no_ack", 32'(done_ack), 32'd0);
    req = 4'b0000;
    cyc();
    check("wd_fault_pulse", 32'(fault), 32'd0);
    check("wd_grant_clr", 32'(grant), 32'd0);
    check("wd_id_held", 32'(fault_id), 32'd2);

    // Asynchronous reset mid-RUN, then priority restarts at station 0.
    req = 4'b1000;
    cyc();
    check("ar_grant", 32'(grant), 32'b1000);
    pause_req = 4'b1000;
    cyc();
    cyc();
    check("ar_pause_before", 32'(wm_timer_pause), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("ar_grant0", 32'(grant), 32'd0);
    check("ar_busy0", 32'(busy), 32'd0);
    check("ar_pause0", 32'(wm_timer_pause), 32'd0);
    check("ar_dbl0", 32'(wm_double_wash), 32'd0);
    check("ar_id0", 32'(fault_id), 32'd0);
    pause_req = 4'b0000;
    @(posedge clk);
    #1 rst = 1'b0;
    req = 4'b1010;
    cyc();
    check("ar_first", 32'(grant), 32'b0010);
    cyc();
    wm_wash_done = 1'b1;
    cyc();
    check("ar_ack", 32'(done_ack), 32'b0010);
    wm_wash_done = 1'b0;
    req = 4'b0000;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
